// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix register-file access blocks.
//   TYPE_*  : register_file access type codes (element / row / column)
//   MAT_*   : register_file matrix select codes
//   stream_state_t : state encoding of the read streamer FSM
package matrix_pkg;

   localparam logic [1:0] TYPE_ELEM = 2'b00;
   localparam logic [1:0] TYPE_ROW  = 2'b01;
   localparam logic [1:0] TYPE_COL  = 2'b10;

   localparam logic [1:0] MAT_A = 2'b00;
   localparam logic [1:0] MAT_B = 2'b01;
   localparam logic [1:0] MAT_C = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } stream_state_t;

endpackage

// File: rtl/matrix_addr_gen.sv
// Combinational register_file address for a row/column access.
//   mode    in  2              TYPE_ROW -> index*size, TYPE_COL -> index, else 0
//   index   in  index_width    row/column number
//   address out address_width  register_file address (unsigned, width-truncated)
module matrix_addr_gen
   import matrix_pkg::*;
#(
   parameter int size          = 10,
   parameter int address_width = $clog2(size*size),
   parameter int index_width   = $clog2(size)
) (
   input  logic [1:0]               mode,
   input  logic [index_width-1:0]   index,
   output logic [address_width-1:0] address
);

   logic [address_width-1:0] index_ext;

   assign index_ext = address_width'(index);

   always_comb begin
      address = '0;
      case (mode)
         TYPE_ROW: address = index_ext * address_width'(size);
         TYPE_COL: address = index_ext;
         default:  address = '0;
      endcase
   end

endmodule

// File: rtl/matrix_read_streamer.sv
// Streams one whole matrix out of register_file, one row or column per beat,
// over a valid/ready interface with a one-beat output buffer.
//   in_clk / in_reset            clock, synchronous active-high reset
//   in_start, in_select_matrix,  start request with matrix (A/B/C) and
//   in_mode                      access mode (rows/columns)
//   out_busy/out_done/out_error  transfer status
//   out_rf_*, in_rf_data         register_file read port (1-cycle latency)
//   out_data/out_valid/in_ready  beat stream; out_index, out_last describe the beat
//
// state | meaning
// IDLE  | waiting for a legal start
// REQ   | read_en asserted for the current row/column
// WAIT  | register_file data arrives, captured at end of cycle
// HOLD  | beat presented, waiting for handshake
// DONE  | one-cycle done pulse
module matrix_read_streamer
   import matrix_pkg::*;
#(
   parameter int size          = 10,
   parameter int cell_width    = 32,
   parameter int width         = cell_width*size,
   parameter int address_width = $clog2(size*size),
   parameter int index_width   = $clog2(size)
) (
   input  logic                     in_clk,
   input  logic                     in_reset,
   input  logic                     in_start,
   input  logic [1:0]               in_select_matrix,
   input  logic [1:0]               in_mode,
   output logic                     out_busy,
   output logic                     out_done,
   output logic                     out_error,
   output logic [address_width-1:0] out_rf_address,
   output logic [1:0]               out_rf_type,
   output logic [1:0]               out_rf_select_matrix,
   output logic                     out_rf_read_en,
   output logic                     out_rf_write_en,
   input  logic [width-1:0]         in_rf_data,
   output logic [width-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     in_ready,
   output logic [index_width-1:0]  out_index,
   output logic                     out_last
);

   stream_state_t state, state_next;

   logic [index_width-1:0] index;
   logic [1:0]             mode_q;
   logic [1:0]             matrix_q;
   logic [width-1:0]       data_q;
   logic                   error_q;
   logic                   start_legal;
   logic                   start_accept;
   logic                   handshake;
   logic                   at_last;

   assign start_legal  = ((in_mode == TYPE_ROW) || (in_mode == TYPE_COL)) &&
                         (in_select_matrix inside {MAT_A, MAT_B, MAT_C});
   assign start_accept = (state == ST_IDLE) && in_start && start_legal;
   assign handshake    = (state == ST_HOLD) && in_ready;
   assign at_last      = (index == index_width'(size-1));

   always_ff @(posedge in_clk) begin
      if (in_reset) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start_accept) state_next = ST_REQ;
         ST_REQ:  state_next = ST_WAIT;
         ST_WAIT: state_next = ST_HOLD;
         ST_HOLD: if (handshake) state_next = at_last ? ST_DONE : ST_REQ;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // index and mode only change on entry to REQ, so the address derived from
   // them holds its last value everywhere else without a separate register.
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         index    <= '0;
         mode_q   <= '0;
         matrix_q <= '0;
         data_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         error_q <= (state == ST_IDLE) && in_start && !start_legal;
         if (start_accept) begin
            index    <= '0;
            mode_q   <= in_mode;
            matrix_q <= in_select_matrix;
         end
         if (state == ST_WAIT) data_q <= in_rf_data;
         if (handshake && !at_last) index <= index + index_width'(1);
      end
   end

   always_comb begin
      out_rf_read_en = 1'b0;
      out_valid      = 1'b0;
      out_busy       = 1'b0;
      out_done       = 1'b0;
      out_last       = 1'b0;
      case (state)
         ST_REQ:  begin out_rf_read_en = 1'b1; out_busy = 1'b1; end
         ST_WAIT: out_busy = 1'b1;
         ST_HOLD: begin out_valid = 1'b1; out_busy = 1'b1; out_last = at_last; end
         ST_DONE: out_done = 1'b1;
         default: ;
      endcase
   end

   matrix_addr_gen #(
      .size          (size),
      .address_width (address_width),
      .index_width   (index_width)
   ) u_addr_gen (
      .mode    (mode_q),
      .index   (index),
      .address (out_rf_address)
   );

   assign out_rf_type          = mode_q;
   assign out_rf_select_matrix = matrix_q;
   assign out_rf_write_en      = 1'b0;
   assign out_data             = data_q;
   assign out_index            = index;
   assign out_error            = error_q;

endmodule
